// File: rtl/ysyx_25020047_pkg.sv
// Shared definitions for the ysyx_25020047 memory arbiter.
//   - FSM state encoding (plain localparam constants)
//   - requester (owner) encoding
//   - default abort timeout, in cycles from grant to memory response
package ysyx_25020047_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

    localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/ysyx_25020047_wdog.sv
// Transaction watchdog for the memory arbiter.
// Ports:
//   clk, rst  : clock and asynchronous active-high reset
//   clear     : restart the count (asserted on grant)
//   enable    : count this cycle (transaction in flight)
//   limit     : number of in-flight cycles allowed
//   expired   : high in the cycle that is the limit-th in-flight cycle
module ysyx_25020047_wdog (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        enable,
    input  logic [31:0] limit,
    output logic        expired
);

    logic [31:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 32'd0;
        end else if (clear) begin
            count <= 32'd0;
        end else if (enable) begin
            count <= count + 32'd1;
        end
    end

    // count holds the number of completed in-flight cycles, so the current
    // cycle is number count+1; it expires when that reaches the limit.
    assign expired = enable && ((count + 32'd1) >= limit);

endmodule

// File: rtl/ysyx_25020047_mem_arb.sv
// Two-requester memory arbiter (IFU fetch / LSU load-store) with a single
// outstanding transaction and a response timeout.
// Ports:
//   clk, rst                         : clock, asynchronous active-high reset
//   ifu_valid/ifu_ready/ifu_addr     : IFU request handshake and address
//   ifu_rvalid                       : IFU response strobe
//   lsu_valid/ready/addr/wen/wdata/wmask : LSU request handshake and fields
//   lsu_rvalid                       : LSU response (load data / store ack)
//   rdata                            : shared response data, zero when idle
//   timeout_err                      : one-cycle pulse on abort
//   mem_valid/ready, mem_addr/wen/wdata/wmask : memory request side
//   mem_rvalid/mem_rdata             : memory response side
module ysyx_25020047_mem_arb
    import ysyx_25020047_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ifu_valid,
    output logic        ifu_ready,
    input  logic [31:0] ifu_addr,
    output logic        ifu_rvalid,
    input  logic        lsu_valid,
    output logic        lsu_ready,
    input  logic [31:0] lsu_addr,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wmask,
    output logic        lsu_rvalid,
    output logic [31:0] rdata,
    output logic        timeout_err,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    logic [1:0] state;
    logic [1:0] state_nxt;
    owner_e     owner;
    owner_e     last_grant;
    logic       grant_ifu;
    logic       grant_lsu;
    logic       busy;
    logic       resp;
    logic       expired;
    logic       abort;
    logic       done;

    // Grant decision; on contention the requester that did not win last
    // time goes first, so after reset (last_grant = IFU) the LSU wins.
    always_comb begin
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        if (state == ST_IDLE) begin
            if (ifu_valid && lsu_valid) begin
                if (last_grant == OWN_IFU) grant_lsu = 1'b1;
                else                       grant_ifu = 1'b1;
            end else if (ifu_valid) begin
                grant_ifu = 1'b1;
            end else if (lsu_valid) begin
                grant_lsu = 1'b1;
            end
        end
    end

    assign busy  = (state == ST_REQ) || (state == ST_WAIT);
    // A real response in WAIT beats a timeout landing in the same cycle.
    assign resp  = (state == ST_WAIT) && mem_rvalid;
    assign abort = expired && !resp;
    assign done  = resp || abort;

    assign ifu_ready   = grant_ifu;
    assign lsu_ready   = grant_lsu;
    assign ifu_rvalid  = done && (owner == OWN_IFU);
    assign lsu_rvalid  = done && (owner == OWN_LSU);
    assign rdata       = resp ? mem_rdata : 32'h0;
    assign timeout_err = abort;
    assign mem_valid   = (state == ST_REQ);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (grant_ifu || grant_lsu) state_nxt = ST_REQ;
            ST_REQ: begin
                if (abort)          state_nxt = ST_IDLE;
                else if (mem_ready) state_nxt = ST_WAIT;
            end
            ST_WAIT: if (done) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            owner      <= OWN_IFU;
            last_grant <= OWN_IFU;
            mem_addr   <= 32'h0;
            mem_wen    <= 1'b0;
            mem_wdata  <= 32'h0;
            mem_wmask  <= 4'h0;
        end else begin
            state <= state_nxt;
            if (grant_ifu) begin
                // Fetches are always reads; write fields are forced clean.
                owner      <= OWN_IFU;
                last_grant <= OWN_IFU;
                mem_addr   <= ifu_addr;
                mem_wen    <= 1'b0;
                mem_wdata  <= 32'h0;
                mem_wmask  <= 4'h0;
            end else if (grant_lsu) begin
                owner      <= OWN_LSU;
                last_grant <= OWN_LSU;
                mem_addr   <= lsu_addr;
                mem_wen    <= lsu_wen;
                mem_wdata  <= lsu_wdata;
                mem_wmask  <= lsu_wmask;
            end
        end
    end

    ysyx_25020047_wdog u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (grant_ifu || grant_lsu),
        .enable  (busy),
        .limit   (32'(TIMEOUT_CYCLES)),
        .expired (expired)
    );

endmodule

// File: tb/tb_ysyx_25020047_mem_arb.sv
// Self-checking bench for ysyx_25020047_mem_arb. Two instances share the
// inputs: dut uses the default timeout, dut_t uses TIMEOUT_CYCLES=4.
module tb_ysyx_25020047_mem_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ifu_valid = 1'b0;
    logic [31:0] ifu_addr = 32'h0;
    logic        lsu_valid = 1'b0;
    logic [31:0] lsu_addr = 32'h0;
    logic        lsu_wen = 1'b0;
    logic [31:0] lsu_wdata = 32'h0;
    logic [3:0]  lsu_wmask = 4'h0;
    logic        mem_ready = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    logic        ifu_ready, lsu_ready, ifu_rvalid, lsu_rvalid, timeout_err, mem_valid, mem_wen;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_wmask;

    logic        ifu_ready_t, lsu_ready_t, ifu_rvalid_t, lsu_rvalid_t, timeout_err_t, mem_valid_t, mem_wen_t;
    logic [31:0] rdata_t, mem_addr_t, mem_wdata_t;
    logic [3:0]  mem_wmask_t;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ysyx_25020047_mem_arb dut (
        .clk(clk), .rst(rst),
        .ifu_valid(ifu_valid), .ifu_ready(ifu_ready), .ifu_addr(ifu_addr), .ifu_rvalid(ifu_rvalid),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_addr(lsu_addr), .lsu_wen(lsu_wen),
        .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask), .lsu_rvalid(lsu_rvalid),
        .rdata(rdata), .timeout_err(timeout_err),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wen(mem_wen),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    ysyx_25020047_mem_arb #(.TIMEOUT_CYCLES(4)) dut_t (
        .clk(clk), .rst(rst),
        .ifu_valid(ifu_valid), .ifu_ready(ifu_ready_t), .ifu_addr(ifu_addr), .ifu_rvalid(ifu_rvalid_t),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready_t), .lsu_addr(lsu_addr), .lsu_wen(lsu_wen),
        .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask), .lsu_rvalid(lsu_rvalid_t),
        .rdata(rdata_t), .timeout_err(timeout_err_t),
        .mem_valid(mem_valid_t), .mem_ready(mem_ready), .mem_addr(mem_addr_t), .mem_wen(mem_wen_t),
        .mem_wdata(mem_wdata_t), .mem_wmask(mem_wmask_t), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    // Control bundle: {ifu_ready, lsu_ready, ifu_rvalid, lsu_rvalid, mem_valid, timeout_err}
    logic [5:0] ctl, ctl_t;
    assign ctl   = {ifu_ready, lsu_ready, ifu_rvalid, lsu_rvalid, mem_valid, timeout_err};
    assign ctl_t = {ifu_ready_t, lsu_ready_t, ifu_rvalid_t, lsu_rvalid_t, mem_valid_t, timeout_err_t};

    typedef struct {
        logic        iv;
        logic        lv;
        logic        mr;
        logic        mrv;
        logic [31:0] mrd;
        logic [5:0]  ctl;
        logic [31:0] rd;
        logic [31:0] ma;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive on the falling edge, compare 2 time units later (before the
    // next rising edge), since several outputs are combinational.
    task automatic drive(input logic iv, input logic lv, input logic mr,
                         input logic mrv, input logic [31:0] mrd);
        @(negedge clk);
        ifu_valid  = iv;
        lsu_valid  = lv;
        mem_ready  = mr;
        mem_rvalid = mrv;
        mem_rdata  = mrd;
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        ifu_valid = 1'b0; lsu_valid = 1'b0; mem_ready = 1'b0;
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        lsu_wen = 1'b0; lsu_wdata = 32'h0; lsu_wmask = 4'h0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got stuck, expected finish");
        $fatal(1);
    end

    initial begin
        ifu_addr = 32'h8000_0000;
        lsu_addr = 32'h8000_1000;

        // Fetch, contention with alternation, stray responses outside WAIT.
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         6'b100000, 32'h0,         32'h0};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         6'b000010, 32'h0,         32'h8000_0000};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0010_0073, 6'b001000, 32'h0010_0073, 32'h8000_0000};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         6'b010000, 32'h0,         32'h8000_0000};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         6'b000010, 32'h0,         32'h8000_1000};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h1122_3344, 6'b000100, 32'h1122_3344, 32'h8000_1000};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         6'b100000, 32'h0,         32'h8000_1000};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         6'b000010, 32'h0,         32'h8000_0000};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         6'b000010, 32'h0,         32'h8000_0000};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         6'b000000, 32'h0,         32'h8000_0000};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'hCAFE_F00D, 6'b001000, 32'hCAFE_F00D, 32'h8000_0000};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         6'b010000, 32'h0,         32'h8000_0000};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h5555_5555, 6'b000010, 32'h0,         32'h8000_1000};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         6'b000000, 32'h0,         32'h8000_1000};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h1234_5678, 6'b000100, 32'h1234_5678, 32'h8000_1000};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 6'b000000, 32'h0,         32'h8000_1000};

        // Reset state while rst is held.
        repeat (2) @(negedge clk);
        #2;
        check("reset_ctl",  {26'd0, ctl}, 32'h0);
        check("reset_addr", mem_addr, 32'h0);
        check("reset_rdata", rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].iv, vecs[i].lv, vecs[i].mr, vecs[i].mrv, vecs[i].mrd);
            check($sformatf("vec%0d_ctl", i),   {26'd0, ctl}, {26'd0, vecs[i].ctl});
            check($sformatf("vec%0d_rdata", i), rdata, vecs[i].rd);
            check($sformatf("vec%0d_addr", i),  mem_addr, vecs[i].ma);
        end

        // Contention right after reset: LSU first, then IFU.
        do_reset();
        drive(1, 1, 0, 0, 32'h0);
        check("cont_first_ctl", {26'd0, ctl}, {26'd0, 6'b010000});
        drive(1, 1, 1, 0, 32'h0);
        drive(1, 1, 0, 1, 32'h0000_00AA);
        check("cont_resp_ctl", {26'd0, ctl}, {26'd0, 6'b000100});
        drive(1, 1, 0, 0, 32'h0);
        check("cont_second_ctl", {26'd0, ctl}, {26'd0, 6'b100000});

        // LSU store with memory stalling for three cycles.
        do_reset();
        lsu_wen = 1'b1; lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
        drive(0, 1, 0, 0, 32'h0);
        check("st_grant_ctl", {26'd0, ctl}, {26'd0, 6'b010000});
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0, 32'h0);
            lsu_wen = 1'b0; lsu_wdata = 32'h0; lsu_wmask = 4'h0; lsu_addr = 32'h0;
            check($sformatf("st_stall%0d_ctl", k), {26'd0, ctl}, {26'd0, 6'b000010});
            check($sformatf("st_stall%0d_addr", k), mem_addr, 32'h8000_1000);
            check($sformatf("st_stall%0d_data", k), mem_wdata, 32'hDEAD_BEEF);
            check($sformatf("st_stall%0d_wm", k), {27'd0, mem_wen, mem_wmask}, {27'd0, 5'b11111});
        end
        drive(0, 0, 1, 0, 32'h0);
        check("st_accept_ctl", {26'd0, ctl}, {26'd0, 6'b000010});
        drive(0, 0, 0, 1, 32'h0);
        check("st_ack_ctl", {26'd0, ctl}, {26'd0, 6'b000100});
        lsu_addr = 32'h8000_1000;

        // IFU grant clears write fields latched by the earlier store.
        drive(1, 0, 0, 0, 32'h0);
        drive(0, 0, 0, 0, 32'h0);
        check("ifu_clean_fields", {mem_wdata[27:0], mem_wen, mem_wmask[2:0]}, 32'h0);

        // Timeout (limit 4): grant at N, WAIT from N+2, abort at N+4.
        do_reset();
        drive(1, 0, 0, 0, 32'h0);
        check("to_grant_ctl", {26'd0, ctl_t}, {26'd0, 6'b100000});
        drive(0, 0, 1, 0, 32'h0);
        drive(0, 0, 0, 0, 32'hAAAA_AAAA);
        check("to_n2_ctl", {26'd0, ctl_t}, 32'h0);
        drive(0, 0, 0, 0, 32'hAAAA_AAAA);
        check("to_n3_ctl", {26'd0, ctl_t}, 32'h0);
        drive(0, 0, 0, 0, 32'hAAAA_AAAA);
        check("to_n4_ctl", {26'd0, ctl_t}, {26'd0, 6'b001001});
        check("to_n4_rdata", rdata_t, 32'h0);
        drive(0, 0, 0, 0, 32'h0);
        check("to_after_ctl", {26'd0, ctl_t}, 32'h0);

        // Response in the expiring cycle wins.
        drive(1, 0, 0, 0, 32'h0);
        check("to2_grant_ctl", {26'd0, ctl_t}, {26'd0, 6'b100000});
        drive(0, 0, 1, 0, 32'h0);
        drive(0, 0, 0, 0, 32'h0);
        drive(0, 0, 0, 0, 32'h0);
        drive(0, 0, 0, 1, 32'h0BAD_F00D);
        check("to2_n4_ctl", {26'd0, ctl_t}, {26'd0, 6'b001000});
        check("to2_n4_rdata", rdata_t, 32'h0BAD_F00D);

        // Reset while in WAIT, then a stray response.
        do_reset();
        drive(1, 0, 0, 0, 32'h0);
        drive(0, 0, 1, 0, 32'h0);
        drive(0, 0, 0, 0, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #2;
        check("rstw_ctl", {26'd0, ctl}, 32'h0);
        check("rstw_addr", mem_addr, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
        #2;
        check("rstw_stray_ctl", {26'd0, ctl}, 32'h0);
        check("rstw_stray_rdata", rdata, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
